// File: rtl/vdata_seq_aligner.sv
// vdata_seq_aligner: multi-beat vector load/store aligner.
// Walks every cache block an access touches, one block per beat.
module vdata_seq_aligner #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int BLOCK_W = 256,
  parameter int SIZE_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [SIZE_W-1:0]  req_size,
  input  logic               req_store,
  input  logic [DATA_W-1:0]  req_data,
  output logic               blk_req_valid,
  input  logic               blk_req_ready,
  output logic [ADDR_W-1:0]  blk_req_addr,
  input  logic               blk_rsp_valid,
  input  logic [BLOCK_W-1:0] blk_rsp_data,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [BLOCK_W-1:0] wr_block,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_data,
  output logic               exc_valid,
  output logic [3:0]         exception
);

  localparam int BB     = BLOCK_W / 8;
  localparam int OFF_W  = $clog2(BB);
  localparam int BEAT_W = $clog2(DATA_W / BLOCK_W + 2);
  localparam int NB     = DATA_W / 8;
  localparam int BA_W   = ADDR_W - OFF_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [OFF_W-1:0]    off_q;
  logic [SIZE_W-1:0]   size_q;
  logic                store_q;
  logic                exc_q;
  logic [BA_W-1:0]     base_q;
  logic [BEAT_W-1:0]   beats_q;
  logic [BEAT_W-1:0]   k_q;
  logic [DATA_W-1:0]   sdata_q;
  logic [DATA_W-1:0]   acc_q;
  logic [BLOCK_W-1:0]  wblk_q;

  logic [DATA_W-1:0]   acc_d;
  logic [BLOCK_W-1:0]  wblk_d;
  logic [OFF_W-1:0]    req_off;
  logic                req_bad;
  logic [BEAT_W-1:0]   req_beats;
  logic                last;
  logic [ADDR_W-1:0]   blk_addr;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_bad   = (req_size == '0) || (req_size > SIZE_W'(NB));
  assign req_beats = BEAT_W'((int'(req_off) + int'(req_size) - 1) / BB + 1);
  assign last      = (k_q == beats_q - 1'b1);
  assign blk_addr  = {base_q + BA_W'(k_q), {OFF_W{1'b0}}};

  // Gather this beat's bytes into the right-aligned load vector.
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < NB; j++) begin
      if (j < int'(size_q) && (int'(off_q) + j) / BB == int'(k_q))
        acc_d[8*j +: 8] = blk_rsp_data[8*((int'(off_q) + j) % BB) +: 8];
    end
  end

  // Overlay the addressed store bytes onto the fetched block.
  always_comb begin
    int idx;
    idx    = 0;
    wblk_d = blk_rsp_data;
    for (int b = 0; b < BB; b++) begin
      idx = int'(k_q) * BB + b - int'(off_q);
      if (idx >= 0 && idx < int'(size_q))
        wblk_d[8*b +: 8] = sdata_q[8*idx +: 8];
    end
  end

  // Sequencer: capture, per-beat fetch/merge/write, then respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      size_q  <= '0;
      store_q <= 1'b0;
      exc_q   <= 1'b0;
      base_q  <= '0;
      beats_q <= '0;
      k_q     <= '0;
      sdata_q <= '0;
      acc_q   <= '0;
      wblk_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            off_q   <= req_off;
            size_q  <= req_size;
            store_q <= req_store;
            sdata_q <= req_data;
            base_q  <= req_addr[ADDR_W-1:OFF_W];
            beats_q <= req_beats;
            exc_q   <= req_bad;
            k_q     <= '0;
            acc_q   <= '0;
            wblk_q  <= '0;
            state_q <= req_bad ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (blk_req_ready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (blk_rsp_valid) begin
            if (store_q) begin
              wblk_q  <= wblk_d;
              state_q <= S_WRITE;
            end else begin
              acc_q <= acc_d;
              if (last) begin
                state_q <= S_DONE;
              end else begin
                k_q     <= k_q + 1'b1;
                state_q <= S_FETCH;
              end
            end
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            if (last) begin
              state_q <= S_DONE;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (resp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign blk_req_valid = (state_q == S_FETCH);
  assign blk_req_addr  = (state_q == S_FETCH) ? blk_addr : '0;
  assign wr_valid      = (state_q == S_WRITE);
  assign wr_addr       = (state_q == S_WRITE) ? blk_addr : '0;
  assign wr_block      = (state_q == S_WRITE) ? wblk_q : '0;
  assign resp_valid    = (state_q == S_DONE);
  assign resp_data     = (state_q == S_DONE && !store_q) ? acc_q : '0;
  assign exc_valid     = (state_q == S_DONE) && exc_q;
  assign exception     = exc_valid ? 4'd1 : 4'd0;

endmodule

// File: tb/tb_vdata_seq_aligner.sv
// tb_vdata_seq_aligner: scoreboard bench for vdata_seq_aligner.
// A flat byte-memory model supplies blocks and predicts results.
module tb_vdata_seq_aligner;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int BW = 256;
  localparam int SW = 6;
  localparam int BB = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [SW-1:0] req_size = '0;
  logic          req_store = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          blk_req_valid;
  logic          blk_req_ready = 1'b0;
  logic [AW-1:0] blk_req_addr;
  logic          blk_rsp_valid = 1'b0;
  logic [BW-1:0] blk_rsp_data = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_block;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          exc_valid;
  logic [3:0]    exception;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int cfg_blk_stall = 0;
  int cfg_wr_stall = 0;
  int cfg_resp_stall = 0;
  bit hold_rsp = 1'b0;
  bit fill_ff = 1'b0;
  int late_req_n = 0;

  int nb = 0;
  int nw = 0;
  int nr = 0;
  int late_done_n = 0;
  bit rsp_pend = 1'b0;
  logic [AW-1:0] rsp_addr = '0;

  logic [AW-1:0] of_addr[$];
  logic [AW-1:0] ow_addr[$];
  logic [BW-1:0] ow_blk[$];
  logic [DW-1:0] or_data[$];
  logic          or_excv[$];
  logic [3:0]    or_exc[$];
  int            or_cyc[$];

  logic [AW-1:0] exp_fetch[$];
  logic [AW-1:0] exp_wa[$];
  logic [BW-1:0] exp_wb[$];
  logic [DW-1:0] exp_data[$];
  bit            exp_exc[$];

  vdata_seq_aligner dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_size(req_size),
    .req_store(req_store),
    .req_data(req_data),
    .blk_req_valid(blk_req_valid),
    .blk_req_ready(blk_req_ready),
    .blk_req_addr(blk_req_addr),
    .blk_rsp_valid(blk_rsp_valid),
    .blk_rsp_data(blk_rsp_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_block(wr_block),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .exc_valid(exc_valid),
    .exception(exception)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return fill_ff ? 8'hFF : a[7:0];
  endfunction

  function automatic logic [BW-1:0] mk_block(input logic [AW-1:0] a);
    logic [BW-1:0] r;
    for (int b = 0; b < BB; b++) r[8*b +: 8] = mem_byte(a + AW'(b));
    return r;
  endfunction

  // Cache / write-back / consumer model; logs every handshake.
  always @(negedge clk) begin
    blk_rsp_valid = 1'b0;
    blk_rsp_data  = '0;
    if (rsp_pend) begin
      blk_rsp_valid = 1'b1;
      blk_rsp_data  = mk_block(rsp_addr);
      rsp_pend      = 1'b0;
    end else if (late_done_n != late_req_n) begin
      blk_rsp_valid = 1'b1;
      blk_rsp_data  = {8{32'hA5A55A5A}};
      late_done_n   = late_req_n;
    end
    blk_req_ready = 1'b0;
    if (blk_req_valid) begin
      if (nb < cfg_blk_stall) nb++;
      else begin
        nb = 0;
        blk_req_ready = 1'b1;
        of_addr.push_back(blk_req_addr);
        rsp_addr = blk_req_addr;
        rsp_pend = !hold_rsp;
      end
    end
    wr_ready = 1'b0;
    if (wr_valid) begin
      if (nw < cfg_wr_stall) nw++;
      else begin
        nw = 0;
        wr_ready = 1'b1;
        ow_addr.push_back(wr_addr);
        ow_blk.push_back(wr_block);
      end
    end
    resp_ready = 1'b0;
    if (resp_valid) begin
      if (nr < cfg_resp_stall) nr++;
      else begin
        nr = 0;
        resp_ready = 1'b1;
        or_data.push_back(resp_data);
        or_excv.push_back(exc_valid);
        or_exc.push_back(exception);
        or_cyc.push_back(cyc);
      end
    end
  end

  function automatic void clear_exp();
    exp_fetch.delete();
    exp_wa.delete();
    exp_wb.delete();
    exp_data.delete();
    exp_exc.delete();
  endfunction

  function automatic void push_expect(input logic [AW-1:0] a, input int sz,
                                      input bit st, input logic [DW-1:0] d);
    logic [AW-1:0] first;
    logic [AW-1:0] blk;
    logic [BW-1:0] m;
    logic [DW-1:0] r;
    int nblk;
    int rel;
    r = '0;
    if (sz == 0 || sz > DW / 8) begin
      exp_data.push_back('0);
      exp_exc.push_back(1'b1);
      return;
    end
    first = a & ~AW'(BB - 1);
    nblk = int'((((a + AW'(sz - 1)) & ~AW'(BB - 1)) - first) / AW'(BB)) + 1;
    for (int i = 0; i < nblk; i++) begin
      blk = first + AW'(BB * i);
      exp_fetch.push_back(blk);
      if (st) begin
        for (int b = 0; b < BB; b++) begin
          rel = int'(blk + AW'(b) - a);
          if (rel >= 0 && rel < sz) m[8*b +: 8] = d[8*rel +: 8];
          else m[8*b +: 8] = mem_byte(blk + AW'(b));
        end
        exp_wa.push_back(blk);
        exp_wb.push_back(m);
      end
    end
    if (!st)
      for (int j = 0; j < sz; j++) r[8*j +: 8] = mem_byte(a + AW'(j));
    exp_data.push_back(r);
    exp_exc.push_back(1'b0);
  endfunction

  task automatic send(input logic [AW-1:0] a, input int sz, input bit st,
                      input logic [DW-1:0] d, output int acc);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = SW'(sz);
    req_store = st;
    req_data  = d;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n, output bit to);
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (or_data.size() > n) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_ready got %b want 1", req_ready);
    end
    checks++;
    if ({blk_req_valid, wr_valid, resp_valid, exc_valid, exception,
         blk_req_addr, wr_addr, wr_block, resp_data} !== '0) begin
      errors++;
      $display("FAIL rst_outputs got nonzero want 0 (bv %b wv %b rv %b)",
               blk_req_valid, wr_valid, resp_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_single();
    int n, nf, acc;
    bit to, ex;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    clear_exp();
    fill_ff = 1'b0;
    n = or_data.size();
    nf = of_addr.size();
    push_expect(32'h1004, 8, 1'b0, '0);
    send(32'h1004, 8, 1'b0, '0, acc);
    wait_resp(n, to);
    checks++;
    if (to) begin errors++; $display("FAIL load1_timeout got timeout want resp"); end
    checks++;
    if (of_addr.size() != nf + 1) begin
      errors++;
      $display("FAIL load1_nfetch got %0d want 1", of_addr.size() - nf);
    end
    ea = exp_fetch.pop_front();
    checks++;
    if (of_addr[nf] !== ea) begin
      errors++;
      $display("FAIL load1_addr got %h want %h", of_addr[nf], ea);
    end
    ed = exp_data.pop_front();
    checks++;
    if (or_data[n] !== ed) begin
      errors++;
      $display("FAIL load1_data got %h want %h", or_data[n], ed);
    end
    checks++;
    if (or_data[n] !== 256'h0B0A090807060504) begin
      errors++;
      $display("FAIL load1_lit got %h want 0b0a090807060504", or_data[n]);
    end
    ex = exp_exc.pop_front();
    checks++;
    if (or_excv[n] !== ex) begin
      errors++;
      $display("FAIL load1_exc got %b want %b", or_excv[n], ex);
    end
    checks++;
    if (or_cyc[n] - acc != 2) begin
      errors++;
      $display("FAIL load1_latency got %0d want 2", or_cyc[n] - acc);
    end
  endtask

  task automatic test_load_cross();
    int n, nf, acc;
    bit to;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    clear_exp();
    fill_ff = 1'b0;
    n = or_data.size();
    nf = of_addr.size();
    push_expect(32'h101C, 32, 1'b0, '0);
    send(32'h101C, 32, 1'b0, '0, acc);
    wait_resp(n, to);
    checks++;
    if (to) begin errors++; $display("FAIL cross_timeout got timeout want resp"); end
    for (int i = 0; i < 2; i++) begin
      ea = exp_fetch.pop_front();
      checks++;
      if (of_addr[nf + i] !== ea) begin
        errors++;
        $display("FAIL cross_addr%0d got %h want %h", i, of_addr[nf + i], ea);
      end
    end
    ed = exp_data.pop_front();
    checks++;
    if (or_data[n] !== ed) begin
      errors++;
      $display("FAIL cross_data got %h want %h", or_data[n], ed);
    end
    checks++;
    if (or_cyc[n] - acc != 4) begin
      errors++;
      $display("FAIL cross_latency got %0d want 4", or_cyc[n] - acc);
    end
  endtask

  task automatic test_store();
    int n, nf, nwr, acc;
    bit to;
    logic [AW-1:0] ea;
    logic [BW-1:0] eb;
    logic [DW-1:0] ed;
    clear_exp();
    fill_ff = 1'b1;
    n = or_data.size();
    nf = of_addr.size();
    nwr = ow_addr.size();
    push_expect(32'h2030, 4, 1'b1, 256'hDEADBEEF);
    send(32'h2030, 4, 1'b1, 256'hDEADBEEF, acc);
    wait_resp(n, to);
    checks++;
    if (to) begin errors++; $display("FAIL store_timeout got timeout want resp"); end
    ea = exp_fetch.pop_front();
    checks++;
    if (of_addr[nf] !== ea) begin
      errors++;
      $display("FAIL store_fetch got %h want %h", of_addr[nf], ea);
    end
    checks++;
    if (ow_addr.size() != nwr + 1) begin
      errors++;
      $display("FAIL store_nwrite got %0d want 1", ow_addr.size() - nwr);
    end
    ea = exp_wa.pop_front();
    checks++;
    if (ow_addr[nwr] !== ea) begin
      errors++;
      $display("FAIL store_waddr got %h want %h", ow_addr[nwr], ea);
    end
    eb = exp_wb.pop_front();
    checks++;
    if (ow_blk[nwr] !== eb) begin
      errors++;
      $display("FAIL store_wblock got %h want %h", ow_blk[nwr], eb);
    end
    ed = exp_data.pop_front();
    checks++;
    if (or_data[n] !== ed) begin
      errors++;
      $display("FAIL store_resp got %h want %h", or_data[n], ed);
    end
    checks++;
    if (or_cyc[n] - acc != 3) begin
      errors++;
      $display("FAIL store_latency got %0d want 3", or_cyc[n] - acc);
    end
    fill_ff = 1'b0;
  endtask

  task automatic test_illegal();
    int n, nf, acc, sz;
    bit to, ex;
    logic [DW-1:0] ed;
    for (int t = 0; t < 2; t++) begin
      sz = (t == 0) ? 0 : 33;
      clear_exp();
      n = or_data.size();
      nf = of_addr.size();
      push_expect(32'h3000, sz, 1'b0, '0);
      send(32'h3000, sz, 1'b0, '0, acc);
      wait_resp(n, to);
      checks++;
      if (to) begin errors++; $display("FAIL illegal%0d_timeout got timeout want resp", sz); end
      checks++;
      if (of_addr.size() != nf) begin
        errors++;
        $display("FAIL illegal%0d_fetch got %0d want 0", sz, of_addr.size() - nf);
      end
      ex = exp_exc.pop_front();
      checks++;
      if (or_excv[n] !== ex) begin
        errors++;
        $display("FAIL illegal%0d_excv got %b want %b", sz, or_excv[n], ex);
      end
      checks++;
      if (or_exc[n] !== 4'd1) begin
        errors++;
        $display("FAIL illegal%0d_code got %0d want 1", sz, or_exc[n]);
      end
      ed = exp_data.pop_front();
      checks++;
      if (or_data[n] !== ed) begin
        errors++;
        $display("FAIL illegal%0d_data got %h want %h", sz, or_data[n], ed);
      end
    end
  endtask

  task automatic test_backpressure();
    int n, nf, nwr, acc, cb, cw, cr, stab, beats;
    bit to, st, pb, pw, pr;
    logic [AW-1:0] a, pa, pwa, ea;
    logic [BW-1:0] pwb, eb;
    logic [DW-1:0] d, prd, ed;
    logic [4:0] pex;
    int sz;
    cfg_blk_stall = 5;
    cfg_wr_stall = 5;
    cfg_resp_stall = 5;
    for (int op = 0; op < 2; op++) begin
      st = (op == 0);
      a = st ? 32'h4014 : 32'h40F0;
      sz = st ? 20 : 24;
      beats = 2;
      d = {8{$urandom()}};
      clear_exp();
      n = or_data.size();
      nf = of_addr.size();
      nwr = ow_addr.size();
      push_expect(a, sz, st, d);
      send(a, sz, st, d, acc);
      cb = 0; cw = 0; cr = 0; stab = 0;
      pb = 0; pw = 0; pr = 0;
      pa = '0; pwa = '0; pwb = '0; prd = '0; pex = '0;
      to = 1'b1;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (blk_req_valid) begin
          cb++;
          if (pb && blk_req_addr !== pa) stab++;
          pa = blk_req_addr;
        end
        pb = blk_req_valid;
        if (wr_valid) begin
          cw++;
          if (pw && (wr_addr !== pwa || wr_block !== pwb)) stab++;
          pwa = wr_addr;
          pwb = wr_block;
        end
        pw = wr_valid;
        if (resp_valid) begin
          cr++;
          if (pr && (resp_data !== prd || {exc_valid, exception} !== pex)) stab++;
          prd = resp_data;
          pex = {exc_valid, exception};
        end
        pr = resp_valid;
        if (or_data.size() > n && !resp_valid) begin
          to = 1'b0;
          break;
        end
      end
      checks++;
      if (to) begin errors++; $display("FAIL bp%0d_timeout got timeout want resp", op); end
      checks++;
      if (stab != 0) begin
        errors++;
        $display("FAIL bp%0d_stable got %0d changes want 0", op, stab);
      end
      checks++;
      if (cb != 6 * beats || cw != (st ? 6 * beats : 0) || cr != 6) begin
        errors++;
        $display("FAIL bp%0d_holdcycles got %0d/%0d/%0d want %0d/%0d/6",
                 op, cb, cw, cr, 6 * beats, st ? 6 * beats : 0);
      end
      for (int i = 0; i < beats; i++) begin
        ea = exp_fetch.pop_front();
        checks++;
        if (of_addr[nf + i] !== ea) begin
          errors++;
          $display("FAIL bp%0d_fetch%0d got %h want %h", op, i, of_addr[nf + i], ea);
        end
      end
      if (st) begin
        for (int i = 0; i < beats; i++) begin
          ea = exp_wa.pop_front();
          eb = exp_wb.pop_front();
          checks++;
          if (ow_addr[nwr + i] !== ea || ow_blk[nwr + i] !== eb) begin
            errors++;
            $display("FAIL bp%0d_write%0d got %h:%h want %h:%h",
                     op, i, ow_addr[nwr + i], ow_blk[nwr + i], ea, eb);
          end
        end
      end
      ed = exp_data.pop_front();
      checks++;
      if (or_data[n] !== ed) begin
        errors++;
        $display("FAIL bp%0d_resp got %h want %h", op, or_data[n], ed);
      end
    end
    cfg_blk_stall = 0;
    cfg_wr_stall = 0;
    cfg_resp_stall = 0;
  endtask

  task automatic test_reset_mid();
    int n, nf, nwr, acc;
    bit to, bad, ex;
    logic [DW-1:0] d, ed;
    logic [AW-1:0] ea;
    logic [BW-1:0] eb;
    fill_ff = 1'b1;
    hold_rsp = 1'b1;
    n = or_data.size();
    nf = of_addr.size();
    nwr = ow_addr.size();
    d = {8{$urandom()}};
    send(32'h2030, 32, 1'b1, d, acc);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (of_addr.size() > nf) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin errors++; $display("FAIL rmid_fetch got none want 1"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 ||
        {blk_req_valid, wr_valid, resp_valid, exc_valid, exception,
         blk_req_addr, wr_addr, wr_block, resp_data} !== '0) begin
      errors++;
      $display("FAIL rmid_cleared got rr %b bv %b wv %b rv %b want 1 0 0 0",
               req_ready, blk_req_valid, wr_valid, resp_valid);
    end
    rst = 1'b0;
    hold_rsp = 1'b0;
    late_req_n++;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (blk_req_valid || wr_valid || resp_valid || !req_ready) bad = 1'b1;
    end
    checks++;
    if (bad || ow_addr.size() != nwr || or_data.size() != n) begin
      errors++;
      $display("FAIL rmid_quiet got activity %b writes %0d resps %0d want 0 0 0",
               bad, ow_addr.size() - nwr, or_data.size() - n);
    end
    clear_exp();
    d = {8{$urandom()}};
    n = or_data.size();
    nwr = ow_addr.size();
    push_expect(32'h2030, 32, 1'b1, d);
    send(32'h2030, 32, 1'b1, d, acc);
    wait_resp(n, to);
    checks++;
    if (to) begin errors++; $display("FAIL rmid_next_timeout got timeout want resp"); end
    for (int i = 0; i < 2; i++) begin
      ea = exp_wa.pop_front();
      eb = exp_wb.pop_front();
      checks++;
      if (ow_addr[nwr + i] !== ea || ow_blk[nwr + i] !== eb) begin
        errors++;
        $display("FAIL rmid_write%0d got %h:%h want %h:%h",
                 i, ow_addr[nwr + i], ow_blk[nwr + i], ea, eb);
      end
    end
    ed = exp_data.pop_front();
    ex = exp_exc.pop_front();
    checks++;
    if (or_data[n] !== ed || or_excv[n] !== ex) begin
      errors++;
      $display("FAIL rmid_resp got %h/%b want %h/%b", or_data[n], or_excv[n], ed, ex);
    end
    fill_ff = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_single();
    test_load_cross();
    test_store();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
